noise_arbiter: RTL and testbench

Shared noise source for the synth voices. It holds a private 24-bit Fibonacci LFSR (taps 23, 3, 2, 0; shift left; feedback into bit 0) and arbitrates it round-robin among NUM_REQ requesters. Each granted request advances the LFSR STEPS times, so every requester receives a fresh, decorrelated sample. It sits between the voice engines and the mixer, and supports runtime reseeding.

---
 rtl/noise_arbiter.sv | 159 +++++++++++++++
 tb/tb_noise_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noise_arbiter
// Purpose  : Shared noise source for the synth voices. A private 24-bit
//            Fibonacci LFSR (taps 23,3,2,0, shift left, feedback into bit 0)
//            is handed out round-robin to NUM_REQ requesters. Each delivered
//            sample is the LFSR advanced STEPS times past the previous one.
// Ports    : clk_i     clock
//            rst_i     asynchronous active-high reset
//            req_i     level request per requester
//            reseed_i  load seed_i into the LFSR (only acted on while idle)
//            seed_i    reseed value (zero selects SEED)
//            valid_o   one-cycle pulse, id_o/data_o valid
//            ack_o     one-hot pulse to the served requester
//            id_o      index of the served requester
//            data_o    noise sample, holds last delivered value
//            busy_o    high while a sample is being produced
// Revision : 1.0  initial release
// ============================================================================
module noise_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          STEPS   = 24,
    parameter logic [23:0] SEED    = 24'h8964CE
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       reseed_i,
    input  logic [23:0]                seed_i,
    output logic                       valid_o,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [$clog2(NUM_REQ)-1:0] id_o,
    output logic [23:0]                data_o,
    output logic                       busy_o
);

    localparam int          ID_W       = $clog2(NUM_REQ);
    localparam logic [7:0]  c_STEPS_M1 = 8'(STEPS - 1);
    localparam logic [ID_W-1:0] c_LAST_RST = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [23:0]     r_lfsr;
    logic [23:0]     w_lfsr_next;
    logic [7:0]      r_cnt;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] r_id;
    logic [23:0]     r_data;
    logic [ID_W-1:0] w_pick;
    logic            w_any_req;

    assign w_any_req   = |req_i;
    assign w_lfsr_next = {r_lfsr[22:0], r_lfsr[23] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0]};

    // Round-robin pick: first set request strictly after the last served index.
    always_comb begin
        int  idx;
        logic found;
        w_pick = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                w_pick = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; reseed wins over a waiting request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!reseed_i && w_any_req) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr  <= SEED;
            r_cnt   <= 8'd0;
            r_grant <= '0;
            r_last  <= c_LAST_RST;
            r_id    <= '0;
            r_data  <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reseed_i) begin
                        r_lfsr <= (seed_i == 24'd0) ? SEED : seed_i;
                    end else if (w_any_req) begin
                        r_grant <= w_pick;
                        r_cnt   <= c_STEPS_M1;
                    end
                end
                S_SHIFT: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_cnt == 8'd0) begin
                        // Capture the finished sample so data_o only ever
                        // shows complete values and holds them afterwards.
                        r_data <= w_lfsr_next;
                        r_id   <= r_grant;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        valid_o = 1'b0;
        ack_o   = '0;
        busy_o  = (r_state != S_IDLE);
        if (r_state == S_DONE) begin
            valid_o        = 1'b1;
            ack_o[r_grant] = 1'b1;
        end
    end

    assign id_o   = r_id;
    assign data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_noise_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noise_arbiter
// Purpose  : Two arbiters (STEPS=24 and STEPS=1) share one stimulus stream.
//            A transaction-level model predicts grant order, sample values
//            and pulse timing for each; literal values pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_noise_arbiter;

    localparam logic [23:0] c_SEED = 24'h8964CE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic        reseed = 1'b0;
    logic [23:0] seed = 24'd0;

    logic [1:0]  valid_w;
    logic [1:0]  busy_w;
    logic [3:0]  ack_w  [2];
    logic [1:0]  id_w   [2];
    logic [23:0] data_w [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noise_arbiter #(.NUM_REQ(4), .STEPS(24), .SEED(c_SEED)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .reseed_i(reseed), .seed_i(seed),
        .valid_o(valid_w[0]), .ack_o(ack_w[0]), .id_o(id_w[0]),
        .data_o(data_w[0]), .busy_o(busy_w[0]));

    noise_arbiter #(.NUM_REQ(4), .STEPS(1), .SEED(c_SEED)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .reseed_i(reseed), .seed_i(seed),
        .valid_o(valid_w[1]), .ack_o(ack_w[1]), .id_o(id_w[1]),
        .data_o(data_w[1]), .busy_o(busy_w[1]));

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [23:0] advance(input logic [23:0] v, input int s);
        logic [23:0] x = v;
        for (int k = 0; k < s; k++) x = {x[22:0], x[23] ^ x[3] ^ x[2] ^ x[0]};
        return x;
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    int          m_steps  [2] = '{24, 1};
    logic [23:0] m_lfsr   [2];
    int          m_last   [2];
    int          m_idle_at[2];   // first edge at which a new request can be sampled
    int          m_pulse_at[2];  // edge after which valid is shown
    int          m_pid    [2];
    logic [23:0] m_pdata  [2];
    logic [23:0] m_data   [2];
    int          m_id     [2];
    int          cyc = 0;

    always @(posedge clk) begin
        logic e_valid [2];
        logic e_busy  [2];
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_lfsr[i] = c_SEED; m_last[i] = 3; m_idle_at[i] = 0;
                m_pulse_at[i] = -1; m_data[i] = 0; m_id[i] = 0;
            end else if (cyc >= m_idle_at[i]) begin
                if (reseed) begin
                    m_lfsr[i] = (seed == 24'd0) ? c_SEED : seed;
                end else if (req != 4'd0) begin
                    m_pid[i]      = rr_pick(m_last[i], req);
                    m_last[i]     = m_pid[i];
                    m_pdata[i]    = advance(m_lfsr[i], m_steps[i]);
                    m_lfsr[i]     = m_pdata[i];
                    m_pulse_at[i] = cyc + m_steps[i];
                    m_idle_at[i]  = cyc + m_steps[i] + 2;
                end
            end
            e_valid[i] = !rst && (cyc == m_pulse_at[i]);
            e_busy[i]  = !rst && (cyc < m_idle_at[i] - 1);
            if (e_valid[i]) begin
                m_data[i] = m_pdata[i];
                m_id[i]   = m_pid[i];
            end
        end
        #1;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("valid", i, 32'(valid_w[i]), 32'(e_valid[i]));
                chk("busy",  i, 32'(busy_w[i]),  32'(e_busy[i]));
                chk("ack",   i, 32'(ack_w[i]),   e_valid[i] ? (32'd1 << m_id[i]) : 32'd0);
                chk("data",  i, 32'(data_w[i]),  32'(m_data[i]));
                if (e_valid[i]) chk("id", i, 32'(id_w[i]), 32'(m_id[i]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #1;
            if (busy_w == 2'b00) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid_b(output int id, output logic [23:0] d);
        bit got = 0;
        id = -1; d = '0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (valid_w[1]) begin
                got = 1; id = int'(id_w[1]); d = data_w[1];
            end
        end
        if (!got) chk("valid_timeout", 1, 32'd0, 32'd1);
    endtask

    initial begin
        int          id;
        logic [23:0] d;
        int          bcnt;

        // Reset values
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 32'(valid_w[i]), 32'd0);
            chk("rst_ack",   i, 32'(ack_w[i]),   32'd0);
            chk("rst_id",    i, 32'(id_w[i]),    32'd0);
            chk("rst_data",  i, 32'(data_w[i]),  32'd0);
            chk("rst_busy",  i, 32'(busy_w[i]),  32'd0);
        end
        @(negedge clk); rst = 1'b0;

        // First sample from STEPS=1 after reset
        @(negedge clk); req = 4'b0001;
        bcnt = 0;
        @(posedge clk); #1; bcnt += int'(busy_w[1]);
        chk("first_valid_early", 1, 32'(valid_w[1]), 32'd0);
        @(posedge clk); #1; bcnt += int'(busy_w[1]);
        chk("first_valid", 1, 32'(valid_w[1]), 32'd1);
        chk("first_ack",   1, 32'(ack_w[1]),   32'b0001);
        chk("first_data",  1, 32'(data_w[1]),  32'h12C99D);
        chk("first_id",    1, 32'(id_w[1]),    32'd0);
        req = 4'b0000;
        @(posedge clk); #1; bcnt += int'(busy_w[1]);
        @(posedge clk); #1; bcnt += int'(busy_w[1]);
        chk("first_busy_cycles", 1, 32'(bcnt), 32'd2);
        wait_idle();

        // Reseed with 1, then request requester 1
        reseed = 1'b1; seed = 24'h000001;
        @(negedge clk); reseed = 1'b0; req = 4'b0010;
        wait_valid_b(id, d); req = 4'b0000;
        chk("reseed1_data", 1, 32'(d), 32'h000003);
        chk("reseed1_id",   1, 32'(id), 32'd1);
        wait_idle();

        // Zero seed selects SEED
        reseed = 1'b1; seed = 24'h000000;
        @(negedge clk); reseed = 1'b0; req = 4'b0010;
        wait_valid_b(id, d); req = 4'b0000;
        chk("reseed0_data", 1, 32'(d), 32'h12C99D);
        wait_idle();

        // Serve 2, then 0101 must go 0 then 2
        req = 4'b0100;
        wait_valid_b(id, d); req = 4'b0000;
        chk("serve2_id", 1, 32'(id), 32'd2);
        wait_idle();
        req = 4'b0101;
        wait_valid_b(id, d);
        chk("wrap_first_id", 1, 32'(id), 32'd0);
        wait_valid_b(id, d); req = 4'b0000;
        chk("wrap_second_id", 1, 32'(id), 32'd2);
        wait_idle();

        // Reseed during SHIFT of the STEPS=24 arbiter is ignored (model checks data)
        req = 4'b1000;
        repeat (4) @(negedge clk);
        req = 4'b0000; reseed = 1'b1; seed = 24'h5A5A5A;
        @(negedge clk); reseed = 1'b0;
        wait_idle();

        // Reset during SHIFT
        req = 4'b0001;
        repeat (5) @(negedge clk);
        req = 4'b0000; rst = 1'b1; #1;
        chk("midrst_busy",  0, 32'(busy_w[0]),  32'd0);
        chk("midrst_valid", 0, 32'(valid_w[0]), 32'd0);
        chk("midrst_ack",   0, 32'(ack_w[0]),   32'd0);
        chk("midrst_data",  0, 32'(data_w[0]),  32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); req = 4'b0001;
        wait_valid_b(id, d); req = 4'b0000;
        chk("postrst_data", 1, 32'(d), 32'h12C99D);
        wait_idle();

        // Continuous demand from all four
        req = 4'b1111;
        repeat (300) @(negedge clk);
        req = 4'b0000;
        wait_idle();

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            reseed = ($urandom_range(0, 24) == 0);
            seed   = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        reseed = 1'b0; req = 4'b0000;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
